// File: rtl/miss_arbiter_pkg.sv
// Shared cache definitions: block geometry defaults and the miss arbiter state encoding.
package miss_arbiter_pkg;

    localparam int unsigned WORDS_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT    = 16;
    localparam int unsigned CNT_W         = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_D,
        FILL_I
    } arb_state_e;

endpackage

// File: rtl/miss_arbiter_fill_counter.sv
// Issue/receive word counters for one block fill, with issue-complete and fill-done flags.
module miss_arbiter_fill_counter
    import miss_arbiter_pkg::*;
#(
    parameter int unsigned WORDS = WORDS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue,
    input  logic             recv,
    output logic [CNT_W-1:0] iss_cnt,
    output logic [CNT_W-1:0] rcv_cnt,
    output logic             iss_done,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_cnt  <= '0;
            rcv_cnt  <= '0;
            iss_done <= 1'b0;
        end else if (clear) begin
            iss_cnt  <= '0;
            rcv_cnt  <= '0;
            iss_done <= 1'b0;
        end else begin
            if (issue) begin
                iss_cnt <= iss_cnt + CNT_W'(1);
                if (iss_cnt == LAST) begin
                    iss_done <= 1'b1;
                end
            end
            if (recv) begin
                rcv_cnt <= rcv_cnt + CNT_W'(1);
            end
        end
    end

    assign done = recv && (rcv_cnt == LAST);

endmodule

// File: rtl/miss_arbiter.sv
// Arbitrates D-side write-through, D-miss and I-miss block fills onto one memory port.
module miss_arbiter
    import miss_arbiter_pkg::*;
#(
    parameter int unsigned WORDS = WORDS_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_miss,
    input  logic [AW-1:0]    i_addr,
    input  logic             d_miss,
    input  logic [AW-1:0]    d_addr,
    input  logic             d_wr_req,
    input  logic [AW-1:0]    d_wr_addr,
    input  logic [AW-1:0]    d_wr_data,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [AW-1:0]    mem_addr,
    output logic [AW-1:0]    mem_data_in,
    input  logic [AW-1:0]    mem_data,
    input  logic             mem_valid,
    output logic             i_data_we,
    output logic             i_tag_we,
    output logic             d_data_we,
    output logic             d_tag_we,
    output logic [CNT_W-1:0] word_num,
    output logic [AW-1:0]    fill_data,
    output logic             i_stall,
    output logic             d_stall,
    output logic             d_wr_ack
);

    localparam logic [AW-1:0] BASE_MASK = ~AW'(2 * WORDS - 1);

    arb_state_e       state_q, state_d;
    logic [AW-1:0]    base_q, base_nxt;
    logic             base_load;
    logic             cnt_clear, issue, recv, iss_done, fill_done;
    logic [CNT_W-1:0] iss_cnt, rcv_cnt;

    miss_arbiter_fill_counter #(.WORDS(WORDS)) u_fill_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .issue    (issue),
        .recv     (recv),
        .iss_cnt  (iss_cnt),
        .rcv_cnt  (rcv_cnt),
        .iss_done (iss_done),
        .done     (fill_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (base_load) begin
                base_q <= base_nxt;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        base_load   = 1'b0;
        base_nxt    = '0;
        cnt_clear   = 1'b0;
        issue       = 1'b0;
        recv        = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        i_data_we   = 1'b0;
        i_tag_we    = 1'b0;
        d_data_we   = 1'b0;
        d_tag_we    = 1'b0;
        fill_data   = '0;
        d_wr_ack    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (d_wr_req) begin
                    state_d = WRITE;
                end else if (d_miss) begin
                    state_d   = FILL_D;
                    base_load = 1'b1;
                    base_nxt  = d_addr & BASE_MASK;
                end else if (i_miss) begin
                    state_d   = FILL_I;
                    base_load = 1'b1;
                    base_nxt  = i_addr & BASE_MASK;
                end
            end
            WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                d_wr_ack    = 1'b1;
                state_d     = IDLE;
            end
            FILL_D, FILL_I: begin
                // Issue runs ahead of receive; words return in issue order.
                issue     = !iss_done;
                mem_en    = issue;
                mem_addr  = issue ? base_q + AW'({iss_cnt, 1'b0}) : '0;
                recv      = mem_valid;
                fill_data = mem_data;
                if (mem_valid) begin
                    if (state_q == FILL_D) begin
                        d_data_we = 1'b1;
                        d_tag_we  = fill_done;
                    end else begin
                        i_data_we = 1'b1;
                        i_tag_we  = fill_done;
                    end
                end
                if (fill_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_num = rcv_cnt;
    assign i_stall  = i_miss | (state_q == FILL_I);
    assign d_stall  = d_miss | (d_wr_req & ~d_wr_ack) | (state_q == FILL_D);

endmodule

// File: tb/tb_miss_arbiter.sv
// Directed and randomized checks of miss_arbiter against a transaction-level reference model.
module tb_miss_arbiter;
    import miss_arbiter_pkg::*;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr, mem_valid = 1'b0;
    logic [15:0] mem_addr, mem_data_in, mem_data = '0, fill_data;
    logic        i_data_we, i_tag_we, d_data_we, d_tag_we, i_stall, d_stall, d_wr_ack;
    logic [2:0]  word_num;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    miss_arbiter #(.WORDS(W), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .i_data_we(i_data_we), .i_tag_we(i_tag_we), .d_data_we(d_data_we), .d_tag_we(d_tag_we),
        .word_num(word_num), .fill_data(fill_data),
        .i_stall(i_stall), .d_stall(d_stall), .d_wr_ack(d_wr_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: a read issued in cycle c returns in cycle c+4, in order.
    logic        dv [4];
    logic [15:0] da [4];
    logic        cap_v, spur = 1'b0;
    logic [15:0] cap_a;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            dv[i] = 1'b0;
            da[i] = '0;
        end
        forever begin
            @(negedge clk);
            cap_v = mem_en && !mem_wr;
            cap_a = mem_addr;
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                dv[i] = dv[i+1];
                da[i] = da[i+1];
            end
            dv[3] = cap_v;
            da[3] = mem_word(cap_a);
            mem_valid = dv[0] || spur;
            mem_data  = dv[0] ? da[0] : (spur ? 16'($urandom) : 16'h0000);
        end
    end

    // Reference model: 0 idle, 1 write, 2 D fill, 3 I fill; counts of words issued/received.
    int          kind = 0, issued = 0, received = 0;
    logic [15:0] base = '0;
    logic        i_srv = 1'b0, d_srv = 1'b0, w_srv = 1'b0;

    initial begin
        logic        e_en, e_wr, e_ack, e_iwe, e_itag, e_dwe, e_dtag, e_ist, e_dst;
        logic [15:0] e_addr, e_din, e_fd;
        int          e_wn;
        forever begin
            @(negedge clk);
            e_en = 0; e_wr = 0; e_ack = 0; e_iwe = 0; e_itag = 0; e_dwe = 0; e_dtag = 0;
            e_addr = '0; e_din = '0; e_fd = '0; e_wn = 0;
            if (!rst_n) begin
                kind = 0; issued = 0; received = 0;
            end else if (kind == 1) begin
                e_en = 1; e_wr = 1; e_ack = 1; e_addr = d_wr_addr; e_din = d_wr_data;
            end else if (kind >= 2) begin
                if (issued < W) begin
                    e_en = 1;
                    e_addr = base + 16'(2 * issued);
                end
                e_wn = received;
                if (mem_valid) begin
                    e_fd = mem_data;
                    if (kind == 2) begin e_dwe = 1; e_dtag = (received == W - 1); end
                    else           begin e_iwe = 1; e_itag = (received == W - 1); end
                end
            end
            e_ist = i_miss | (rst_n && kind == 3);
            e_dst = d_miss | (d_wr_req & ~e_ack) | (rst_n && kind == 2);

            chk("m_mem_en", mem_en, e_en);
            chk("m_mem_wr", mem_wr, e_wr);
            chk("m_d_wr_ack", d_wr_ack, e_ack);
            chk("m_i_data_we", i_data_we, e_iwe);
            chk("m_i_tag_we", i_tag_we, e_itag);
            chk("m_d_data_we", d_data_we, e_dwe);
            chk("m_d_tag_we", d_tag_we, e_dtag);
            chk("m_word_num", word_num, 32'(e_wn));
            chk("m_i_stall", i_stall, e_ist);
            chk("m_d_stall", d_stall, e_dst);
            if (e_en || kind == 0) chk("m_mem_addr", mem_addr, e_addr);
            if (kind <= 1) chk("m_mem_data_in", mem_data_in, e_din);
            if (e_iwe || e_dwe || kind == 0) chk("m_fill_data", fill_data, e_fd);

            if (rst_n) begin
                case (kind)
                    0: begin
                        issued = 0; received = 0;
                        if (d_wr_req) kind = 1;
                        else if (d_miss) begin kind = 2; base = d_addr & ~16'(2 * W - 1); end
                        else if (i_miss) begin kind = 3; base = i_addr & ~16'(2 * W - 1); end
                    end
                    1: begin kind = 0; w_srv = 1; end
                    default: begin
                        if (issued < W) issued++;
                        if (mem_valid) begin
                            if (received == W - 1) begin
                                if (kind == 2) d_srv = 1; else i_srv = 1;
                                kind = 0;
                            end else received++;
                        end
                    end
                endcase
            end
        end
    end

    // Random requester: level requests held until the model says they were serviced.
    logic rand_on = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) begin
                if (i_srv) begin i_miss = 0; i_srv = 0; end
                else if (!i_miss && $urandom_range(3) == 0) begin i_miss = 1; i_addr = 16'($urandom); end
                else if ($urandom_range(7) == 0) i_addr = 16'($urandom);
                if (d_srv) begin d_miss = 0; d_srv = 0; end
                else if (!d_miss && $urandom_range(4) == 0) begin d_miss = 1; d_addr = 16'($urandom); end
                else if ($urandom_range(7) == 0) d_addr = 16'($urandom);
                if (w_srv) begin d_wr_req = 0; w_srv = 0; end
                else if (!d_wr_req && $urandom_range(9) == 0) begin
                    d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
                end
                spur = (kind <= 1) && ($urandom_range(7) == 0);
            end else begin
                i_srv = 0; d_srv = 0; w_srv = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Twelve cycles of a block fill starting the cycle after the request is taken.
    task automatic run_fill(input string tg, input bit is_d, input logic [15:0] b, input bit poke);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (poke && c == 4) d_addr = 16'h9000;
            @(negedge clk);
            chk({tg, "_mem_en"}, mem_en, 32'(c <= 8));
            if (c <= 8) chk({tg, "_mem_addr"}, mem_addr, 32'(b + 16'(2 * (c - 1))));
            chk({tg, "_data_we"}, is_d ? d_data_we : i_data_we, 32'(c >= 5));
            chk({tg, "_other_we"}, is_d ? i_data_we : d_data_we, 0);
            if (c >= 5) begin
                chk({tg, "_word_num"}, word_num, 32'(c - 5));
                chk({tg, "_fill_data"}, fill_data, 32'(mem_word(b + 16'(2 * (c - 5)))));
            end
            chk({tg, "_tag_we"}, is_d ? d_tag_we : i_tag_we, 32'(c == 12));
            chk({tg, "_i_stall"}, i_stall, 32'(i_miss | !is_d));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_word_num", word_num, 0);
        chk("rst_i_stall", i_stall, 0);
        tick();
        rst_n = 1;
        repeat (2) tick();

        // single I miss
        i_miss = 1; i_addr = 16'h1236;
        run_fill("r27", 0, 16'h1230, 0);
        tick(); i_miss = 0;
        repeat (2) tick();

        // simultaneous I and D miss: D first
        i_miss = 1; i_addr = 16'h1236; d_miss = 1; d_addr = 16'h4008;
        run_fill("r28d", 1, 16'h4000, 0);
        tick(); d_miss = 0;
        @(negedge clk);
        chk("r28_idle_mem_en", mem_en, 0);
        chk("r28_idle_i_stall", i_stall, 1);
        run_fill("r28i", 0, 16'h1230, 0);
        tick(); i_miss = 0;
        repeat (2) tick();

        // write-through beats a pending D miss
        d_wr_req = 1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_miss = 1; d_addr = 16'h2A46;
        @(negedge clk);
        chk("r29_c0_d_stall", d_stall, 1);
        chk("r29_c0_mem_en", mem_en, 0);
        tick();
        @(negedge clk);
        chk("r29_mem_wr", mem_wr, 1);
        chk("r29_mem_addr", mem_addr, 32'h2002);
        chk("r29_mem_data_in", mem_data_in, 32'hBEEF);
        chk("r29_ack", d_wr_ack, 1);
        tick(); d_wr_req = 0;
        @(negedge clk);
        chk("r29_ack_once", d_wr_ack, 0);
        run_fill("r29", 1, 16'h2A40, 0);
        tick(); d_miss = 0;
        repeat (2) tick();

        // reset while the 5th word of a D fill arrives
        d_miss = 1; d_addr = 16'h5000;
        repeat (8) tick();
        tick(); rst_n = 0; d_miss = 0;
        @(negedge clk);
        chk("r30_d_data_we", d_data_we, 0);
        chk("r30_mem_en", mem_en, 0);
        chk("r30_d_stall", d_stall, 0);
        for (int k = 0; k < 9; k++) begin
            if (k == 5) rst_n = 1;
            tick();
            @(negedge clk);
            chk("r30_no_tag", d_tag_we, 0);
        end
        tick(); d_miss = 1; d_addr = 16'h6004;
        run_fill("r30", 1, 16'h6000, 0);
        tick(); d_miss = 0;
        repeat (2) tick();

        // spurious valid while idle
        spur = 1;
        repeat (3) begin
            @(negedge clk);
            chk("r31_d_data_we", d_data_we, 0);
            chk("r31_i_data_we", i_data_we, 0);
            chk("r31_word_num", word_num, 0);
            tick();
        end
        spur = 0;
        tick();

        // address change mid-fill is ignored
        d_miss = 1; d_addr = 16'h7008;
        run_fill("r32", 1, 16'h7000, 1);
        tick(); d_miss = 0;
        repeat (2) tick();

        rand_on = 1;
        repeat (3000) tick();
        rand_on = 0;
        i_miss = 0; d_miss = 0; d_wr_req = 0; spur = 0;
        repeat (30) tick();
        chk("end_idle", 32'(kind), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
